// File: rtl/ram_1r1w_sync_clr.sv
// One-write/one-read synchronous RAM with per-lane write masks, write-first forwarding,
// optional output register and a clear sweep that re-initialises every word after reset or on request.
//
// state     | meaning
// st_clear  | sweeping clear_val_p into mem[cnt], one word per edge; ports ignored
// st_ready  | normal read/write operation; clear_i starts a new sweep
module ram_1r1w_sync_clr #(
    parameter int width_p = 8,
    parameter int depth_p = 512,
    parameter int lanes_p = 1,
    parameter int out_reg_p = 0,
    parameter logic [width_p-1:0] clear_val_p = '0
) (
    input  logic                       clk_i,
    input  logic                       reset_ni,
    input  logic                       clear_i,
    output logic                       busy_o,
    input  logic                       wr_valid_i,
    input  logic [lanes_p-1:0]         wr_mask_i,
    input  logic [$clog2(depth_p)-1:0] wr_addr_i,
    input  logic [width_p-1:0]         wr_data_i,
    input  logic                       rd_valid_i,
    input  logic [$clog2(depth_p)-1:0] rd_addr_i,
    output logic [width_p-1:0]         rd_data_o,
    output logic                       rd_valid_o
);

    localparam int aw_lp = $clog2(depth_p);
    localparam int lw_lp = width_p / lanes_p;
    localparam logic [aw_lp:0]   depth_lp = (aw_lp + 1)'(depth_p);
    localparam logic [aw_lp-1:0] last_lp  = aw_lp'(depth_p - 1);

    typedef enum logic {st_clear, st_ready} state_e;

    state_e           state_q, state_d;
    logic [aw_lp-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q <= st_clear;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        busy_o  = 1'b0;
        case (state_q)
            st_clear: begin
                busy_o = 1'b1;
                if (cnt_q == last_lp) begin
                    state_d = st_ready;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            st_ready: begin
                if (clear_i) state_d = st_clear;
            end
            default: state_d = st_clear;
        endcase
    end

    logic clearing, wr_in_range, rd_in_range, wr_fire, rd_fire;

    assign clearing    = (state_q == st_clear);
    assign wr_in_range = {1'b0, wr_addr_i} < depth_lp;
    assign rd_in_range = {1'b0, rd_addr_i} < depth_lp;
    assign wr_fire     = !clearing && !clear_i && wr_valid_i && wr_in_range;
    assign rd_fire     = !clearing && !clear_i && rd_valid_i;

    // Single write port shared by the sweep and user writes keeps the array inferable.
    logic [lanes_p-1:0] ram_we;
    logic [aw_lp-1:0]   ram_addr;
    logic [width_p-1:0] ram_wdata;

    always_comb begin
        ram_we    = '0;
        ram_addr  = wr_addr_i;
        ram_wdata = wr_data_i;
        if (clearing) begin
            ram_we    = '1;
            ram_addr  = cnt_q;
            ram_wdata = clear_val_p;
        end else if (wr_fire) begin
            ram_we = wr_mask_i;
        end
    end

    logic [width_p-1:0] mem_r [depth_p];
    logic [width_p-1:0] ram_q;

    always_ff @(posedge clk_i) begin
        for (int k = 0; k < lanes_p; k++) begin
            if (ram_we[k]) mem_r[ram_addr][k*lw_lp +: lw_lp] <= ram_wdata[k*lw_lp +: lw_lp];
        end
        if (rd_fire && rd_in_range) ram_q <= mem_r[rd_addr_i];
    end

    // sel_q low means "output zero": covers both reset and out-of-range reads.
    logic               v1_q, sel_q, hit_q;
    logic [width_p-1:0] fwd_data_q;
    logic [lanes_p-1:0] fwd_mask_q;

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            v1_q       <= 1'b0;
            sel_q      <= 1'b0;
            hit_q      <= 1'b0;
            fwd_data_q <= '0;
            fwd_mask_q <= '0;
        end else begin
            v1_q <= rd_fire;
            if (rd_fire) begin
                sel_q      <= rd_in_range;
                hit_q      <= wr_fire && (wr_addr_i == rd_addr_i);
                fwd_data_q <= wr_data_i;
                fwd_mask_q <= wr_mask_i;
            end
        end
    end

    logic [width_p-1:0] rd_merged;

    always_comb begin
        rd_merged = '0;
        if (sel_q) begin
            for (int k = 0; k < lanes_p; k++) begin
                rd_merged[k*lw_lp +: lw_lp] = (hit_q && fwd_mask_q[k]) ? fwd_data_q[k*lw_lp +: lw_lp]
                                                                       : ram_q[k*lw_lp +: lw_lp];
            end
        end
    end

    if (out_reg_p != 0) begin : g_out_reg
        logic [width_p-1:0] data2_q;
        logic               v2_q;

        always_ff @(posedge clk_i or negedge reset_ni) begin
            if (!reset_ni) begin
                data2_q <= '0;
                v2_q    <= 1'b0;
            end else begin
                v2_q <= v1_q;
                if (v1_q) data2_q <= rd_merged;
            end
        end

        assign rd_data_o  = data2_q;
        assign rd_valid_o = v2_q;
    end else begin : g_no_out_reg
        assign rd_data_o  = rd_merged;
        assign rd_valid_o = v1_q;
    end

endmodule

// File: tb/tb_ram_1r1w_sync_clr.sv
// Bench for ram_1r1w_sync_clr: one latency-1 and one latency-2 instance share stimulus and are
// compared every cycle against a word-array model, plus literal checks of the documented scenarios.
module tb_ram_1r1w_sync_clr;

    localparam int W = 16;
    localparam int D = 12;
    localparam logic [15:0] CV = 16'hA5C3;

    logic        clk_i = 1'b0;
    logic        reset_ni;
    logic        clear_i, wr_valid_i, rd_valid_i;
    logic [1:0]  wr_mask_i;
    logic [3:0]  wr_addr_i, rd_addr_i;
    logic [15:0] wr_data_i;
    logic        busy0, busy1, rvalid0, rvalid1;
    logic [15:0] rdata0, rdata1;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b1;

    always #5 clk_i = ~clk_i;

    ram_1r1w_sync_clr #(.width_p(W), .depth_p(D), .lanes_p(2), .out_reg_p(0), .clear_val_p(CV)) dut0 (
        .clk_i(clk_i), .reset_ni(reset_ni), .clear_i(clear_i), .busy_o(busy0),
        .wr_valid_i(wr_valid_i), .wr_mask_i(wr_mask_i), .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i),
        .rd_valid_i(rd_valid_i), .rd_addr_i(rd_addr_i), .rd_data_o(rdata0), .rd_valid_o(rvalid0));

    ram_1r1w_sync_clr #(.width_p(W), .depth_p(D), .lanes_p(2), .out_reg_p(1), .clear_val_p(CV)) dut1 (
        .clk_i(clk_i), .reset_ni(reset_ni), .clear_i(clear_i), .busy_o(busy1),
        .wr_valid_i(wr_valid_i), .wr_mask_i(wr_mask_i), .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i),
        .rd_valid_i(rd_valid_i), .rd_addr_i(rd_addr_i), .rd_data_o(rdata1), .rd_valid_o(rvalid1));

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: word array, remaining-words-to-clear count, and the expected outputs.
    logic [15:0] m_mem [16];
    int          clear_left;
    logic        e0_v, e1_v;
    logic [15:0] e0_d, e1_d;

    function automatic logic [15:0] model_read(input logic [3:0] ra, input logic we, input logic [1:0] mk,
                                               input logic [3:0] wa, input logic [15:0] wd);
        logic [15:0] r;
        if (int'(ra) >= D) return 16'h0;
        r = m_mem[ra];
        if (we && wa == ra) begin
            for (int k = 0; k < 2; k++) if (mk[k]) r[k*8 +: 8] = wd[k*8 +: 8];
        end
        return r;
    endfunction

    always @(posedge clk_i) begin
        if (!reset_ni) begin
            clear_left = D;
            e0_v = 1'b0; e1_v = 1'b0; e0_d = '0; e1_d = '0;
        end else begin
            e1_v = e0_v;
            if (e0_v) e1_d = e0_d;
            e0_v = 1'b0;
            if (clear_left > 0) begin
                m_mem[D - clear_left] = CV;
                clear_left--;
            end else if (clear_i) begin
                clear_left = D;
            end else begin
                if (rd_valid_i) begin
                    e0_v = 1'b1;
                    e0_d = model_read(rd_addr_i, wr_valid_i, wr_mask_i, wr_addr_i, wr_data_i);
                end
                if (wr_valid_i && int'(wr_addr_i) < D) begin
                    for (int k = 0; k < 2; k++)
                        if (wr_mask_i[k]) m_mem[wr_addr_i][k*8 +: 8] = wr_data_i[k*8 +: 8];
                end
            end
        end
    end

    always @(negedge clk_i) begin
        if (cmp_en) begin
            if (!reset_ni) begin
                chk("rst_busy0", busy0, 1);     chk("rst_busy1", busy1, 1);
                chk("rst_rvalid0", rvalid0, 0); chk("rst_rvalid1", rvalid1, 0);
                chk("rst_rdata0", rdata0, 0);   chk("rst_rdata1", rdata1, 0);
            end else begin
                chk("busy0", busy0, clear_left > 0);
                chk("busy1", busy1, clear_left > 0);
                chk("rvalid0", rvalid0, e0_v);
                chk("rdata0", rdata0, e0_d);
                chk("rvalid1", rvalid1, e1_v);
                chk("rdata1", rdata1, e1_d);
            end
        end
    end

    task automatic drive(input logic we, input logic [1:0] mk, input logic [3:0] wa, input logic [15:0] wd,
                         input logic re, input logic [3:0] ra, input logic clr);
        wr_valid_i = we; wr_mask_i = mk; wr_addr_i = wa; wr_data_i = wd;
        rd_valid_i = re; rd_addr_i = ra; clear_i = clr;
        @(negedge clk_i);
        #1;
    endtask

    task automatic idle();
        drive(0, 2'b00, 4'd0, 16'h0, 0, 4'd0, 0);
    endtask

    task automatic wr(input logic [3:0] wa, input logic [15:0] wd, input logic [1:0] mk);
        drive(1, mk, wa, wd, 0, 4'd0, 0);
    endtask

    task automatic rd(input logic [3:0] ra);
        drive(0, 2'b00, 4'd0, 16'h0, 1, ra, 0);
    endtask

    task automatic count_sweep(input string name);
        int n = 0;
        while (busy0 && n < 50) begin
            idle();
            n++;
        end
        chk(name, n, D);
    endtask

    initial begin
        reset_ni = 1'b0;
        clear_i = 0; wr_valid_i = 0; wr_mask_i = 0; wr_addr_i = 0; wr_data_i = 0;
        rd_valid_i = 0; rd_addr_i = 0;
        @(negedge clk_i);
        @(negedge clk_i);
        #1;
        reset_ni = 1'b1;
        count_sweep("sweep_len_after_reset");

        for (int a = 0; a < D; a++) rd(4'(a));
        rd(4'd7);
        chk("clear_val_rvalid", rvalid0, 1);
        chk("clear_val_data", rdata0, 16'hA5C3);

        wr(4'd3, 16'h1234, 2'b11);
        wr(4'd3, 16'hABCD, 2'b10);
        rd(4'd3);
        chk("masked_write", rdata0, 16'hAB34);

        wr(4'd5, 16'h1111, 2'b11);
        drive(1, 2'b01, 4'd5, 16'hBEEF, 1, 4'd5, 0);
        chk("collision_fwd0", rdata0, 16'h11EF);
        idle();
        chk("collision_fwd1", rdata1, 16'h11EF);
        chk("hold_rvalid0", rvalid0, 0);
        chk("hold_rdata0", rdata0, 16'h11EF);
        rd(4'd5);
        chk("collision_later", rdata0, 16'h11EF);

        wr(4'd0, 16'h0A0A, 2'b11);
        wr(4'd1, 16'h1B1B, 2'b11);
        wr(4'd2, 16'h2C2C, 2'b11);
        rd(4'd0);
        chk("b2b_lat2_first_low", rvalid1, 0);
        rd(4'd1);
        chk("b2b_v0", rvalid1, 1); chk("b2b_d0", rdata1, 16'h0A0A);
        rd(4'd2);
        chk("b2b_v1", rvalid1, 1); chk("b2b_d1", rdata1, 16'h1B1B);
        idle();
        chk("b2b_v2", rvalid1, 1); chk("b2b_d2", rdata1, 16'h2C2C);
        idle();
        chk("b2b_end", rvalid1, 0);

        wr(4'd13, 16'hDEAD, 2'b11);
        rd(4'd13);
        chk("oor_rvalid", rvalid0, 1);
        chk("oor_rdata", rdata0, 16'h0000);

        drive(1, 2'b11, 4'd2, 16'h0055, 1, 4'd2, 1);
        chk("clear_drops_read", rvalid0, 0);
        chk("clear_busy", busy0, 1);
        count_sweep("sweep_len_after_clear");
        rd(4'd2);
        chk("clear_wipes_write", rdata0, 16'hA5C3);

        drive(0, 2'b00, 4'd0, 16'h0, 0, 4'd0, 1);
        repeat (4) idle();
        reset_ni = 1'b0;
        #1;
        chk("midsweep_rst_rdata", rdata0, 16'h0000);
        chk("midsweep_rst_busy", busy0, 1);
        idle();
        idle();
        reset_ni = 1'b1;
        count_sweep("sweep_len_after_midsweep_reset");

        for (int i = 0; i < 600; i++) begin
            logic [3:0] wa;
            wa = 4'($urandom_range(0, 13));
            drive(1'($urandom), 2'($urandom), wa, 16'($urandom), 1'($urandom),
                  ($urandom % 3 == 0) ? wa : 4'($urandom_range(0, 13)), ($urandom % 80) == 0);
        end
        idle();
        while (busy0) idle();
        for (int a = 0; a < 14; a++) rd(4'(a));
        idle();
        idle();
        idle();

        cmp_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
